clk_div_prog_multi: RTL and testbench
=====================================

// Module: clk_div_prog_multi
// PURPOSE
//  Multi-channel programmable clock divider; successor to the fixed-ratio divider.
//  Each channel divides clk by a runtime divisor: any integer >= 1, odd or even.
//  Each channel produces a near-50% divided level plus a one-cycle tick at each period start.
//  Divisor changes take effect only at period boundaries, so no runt periods occur.
//  Sits in the clocking/timing area; tick is the preferred enable for downstream logic.
// PARAMETERS
//  CHANNELS  4   number of independent divider channels (>= 1)
//  WIDTH     8   divisor width in bits; max ratio 2^WIDTH-1
// PORTS
//  clk       in   1               system clock, all logic on posedge
//  reset     in   1               asynchronous, active-low reset (0 = reset)
//  enable    in   CHANNELS        per-channel run enable, level
//  sync      in   1               one-cycle pulse; restarts all enabled channels in phase
//  div       in   CHANNELS*WIDTH  per-channel divisor; ch i = div[i*WIDTH +: WIDTH]
//  clk_out   out  CHANNELS        divided level per channel
//  tick      out  CHANNELS        1-cycle pulse at the first cycle of each period
//  running   out  CHANNELS        channel is dividing with a nonzero active divisor
// BEHAVIOUR
//  Reset (reset=0, async): clk_out=0, tick=0, running=0, cnt=0, active divisor D=0.
//  All outputs are registered; no combinational path from inputs to outputs.
//  Per channel: count cnt in [0,D-1]; high phase H=ceil(D/2), i.e. (D+1)>>1.
//  While running, in a cycle where cnt==c: clk_out==(c<H), tick==(c==0).
//  Count step: cnt <= (cnt==D-1) ? 0 : cnt+1.
//  Divisor load: D is loaded from div[i] only at these points:
//    (a) enable rise, (b) sync, (c) wrap, cnt==D-1.
//    Writes to div mid-period are ignored until the next load point.
//  Start latency: enable sampled 1 while idle -> next cycle running=1, cnt=0, clk_out=1, tick=1.
//  Stop: enable sampled 0 -> next cycle cnt=0, clk_out=0, tick=0, running=0.
//    Stop takes effect immediately, mid-period included.
//  div=0 at a load point: channel idles (outputs 0, running=0).
//    An idle channel re-samples div every cycle while enabled.
//    The first nonzero value behaves as a start: next cycle cnt=0, tick=1.
//  D=1: H=1 and cnt stays 0; clk_out constant 1, tick=1 every cycle.
//  sync=1: every enabled channel -> next cycle cnt=0, D reloaded, tick=1 (if D!=0).
//    Disabled channels ignore sync.
//  sync coincident with wrap: identical result (single reload, cnt=0).
//  sync coincident with enable rise: treated as a start; same result.
//  Channels are fully independent apart from the shared sync.
//  Arithmetic: cnt and D are WIDTH bits; H is WIDTH bits; no overflow for D <= 2^WIDTH-1.
//  Reset asserted mid-period clears state immediately (async).
//  Release is a synchronous restart: first running cycle follows enable as for a start.
// TESTING
//  1 div=4, enable rise -> clk_out 1100 1100..., tick 1000 1000..., running=1 from cycle 1.
//  2 div=3 -> clk_out 110 110..., tick 100...; div=1 -> clk_out=1, tick=1 every cycle.
//  3 div=4 running, write div=6 at cnt=1 -> finish 4-cycle period, then clk_out 111000, no runt.
//  4 ch0 div=3, ch1 div=5 free-running; pulse sync -> next cycle both tick=1, cnt=0, in phase.
//  5 enable low at cnt=2 -> next cycle all outputs 0; div=0 with enable=1 -> running stays 0.
//    Then div=2 -> next cycle tick=1.
//  6 assert reset mid-period -> outputs 0 within the same cycle; release with enable=1 -> clean restart.
//    Also: random div/enable/sync vs. reference model, CHANNELS=1 and CHANNELS=4.

Source files
------------

// File: rtl/clk_div_prog_multi.sv
// Multi-channel programmable clock divider: each channel divides clk by a runtime divisor,
// producing a near-50% level, a period-start tick and a running flag, all registered.
module clk_div_prog_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       enable,
  input  logic                      sync,
  input  logic [CHANNELS*WIDTH-1:0] div,
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       running
);

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH:0]   ONE_X = (WIDTH+1)'(1);

  // High-phase length ceil(D/2); computed one bit wider so D = 2^WIDTH-1 cannot overflow.
  function automatic logic [WIDTH-1:0] high_len(input logic [WIDTH-1:0] d);
    logic [WIDTH:0] sum;
    sum = {1'b0, d} + ONE_X;
    return sum[WIDTH:1];
  endfunction

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [WIDTH-1:0] div_ch;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             run_d, clk_d, tick_d, load;

    assign div_ch = div[ch*WIDTH +: WIDTH];

    // Load points: idle (covers enable rise and div=0 re-sampling), sync, or period wrap.
    always_comb begin
      cnt_d  = '0;
      d_d    = d_q;
      run_d  = 1'b0;
      clk_d  = 1'b0;
      tick_d = 1'b0;
      load   = !running[ch] || sync || (cnt_q == d_q - ONE);
      if (!enable[ch]) begin
        d_d = '0;
      end else if (load) begin
        d_d = div_ch;
        if (div_ch != '0) begin
          run_d  = 1'b1;
          clk_d  = 1'b1;
          tick_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + ONE;
        run_d = 1'b1;
        clk_d = (cnt_d < high_len(d_q));
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q       <= '0;
        d_q         <= '0;
        running[ch] <= 1'b0;
        clk_out[ch] <= 1'b0;
        tick[ch]    <= 1'b0;
      end else begin
        cnt_q       <= cnt_d;
        d_q         <= d_d;
        running[ch] <= run_d;
        clk_out[ch] <= clk_d;
        tick[ch]    <= tick_d;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_prog_multi.sv
// Scoreboard bench for clk_div_prog_multi: a 4-channel and a 1-channel instance checked
// cycle by cycle against a behavioural model, plus directed waveform-pattern checks.
module tb_clk_div_prog_multi;
  localparam int CH = 4;
  localparam int W  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [CH-1:0]     enable;
  logic              sync;
  logic [CH*W-1:0]   div;
  logic [CH-1:0]     clk_out, tick, running;
  logic              clk_out1, tick1, running1;

  int errs   = 0;
  int checks = 0;

  int m_cnt [CH];
  int m_d   [CH];
  bit m_run [CH];

  logic [14:0] exp_q[$];
  logic [15:0] cap_clk, cap_tick;

  always #5 clk = ~clk;

  clk_div_prog_multi #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sync(sync), .div(div),
    .clk_out(clk_out), .tick(tick), .running(running)
  );

  clk_div_prog_multi #(.CHANNELS(1), .WIDTH(W)) dut1 (
    .clk(clk), .reset(reset), .enable(enable[0]), .sync(sync), .div(div[W-1:0]),
    .clk_out(clk_out1), .tick(tick1), .running(running1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < CH; i++) begin
      m_cnt[i] = 0; m_d[i] = 0; m_run[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    int dv;
    for (int i = 0; i < CH; i++) begin
      dv = int'(div[i*W +: W]);
      if (!enable[i]) begin
        m_run[i] = 1'b0; m_cnt[i] = 0; m_d[i] = 0;
      end else if (!m_run[i] || sync || m_cnt[i] == m_d[i] - 1) begin
        m_d[i] = dv; m_cnt[i] = 0; m_run[i] = (dv != 0);
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
  endtask

  function automatic logic [14:0] model_out();
    logic [CH-1:0] co, tk, rn;
    for (int i = 0; i < CH; i++) begin
      rn[i] = m_run[i];
      co[i] = m_run[i] && (m_cnt[i] < (m_d[i] + 1) / 2);
      tk[i] = m_run[i] && (m_cnt[i] == 0);
    end
    return {co[0], tk[0], rn[0], co, tk, rn};
  endfunction

  task automatic cycle(input string tag);
    logic [14:0] got;
    model_step();
    exp_q.push_back(model_out());
    @(posedge clk); #1;
    got = {clk_out1, tick1, running1, clk_out, tick, running};
    chk(tag, got, exp_q.pop_front());
    cap_clk  = {cap_clk[14:0], clk_out[0]};
    cap_tick = {cap_tick[14:0], tick[0]};
  endtask

  task automatic set_div(input int i, input int v);
    div[i*W +: W] = W'(v);
  endtask

  initial begin
    reset = 1'b0; enable = '0; sync = 1'b0; div = '0;
    cap_clk = '0; cap_tick = '0;
    model_clear();
    #1;
    chk("reset_state", {clk_out1, tick1, running1, clk_out, tick, running}, 15'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // 1: div=4 from enable rise
    set_div(0, 4); enable = 4'b0001;
    for (int k = 0; k < 8; k++) cycle("t1");
    chk("t1_clk",  cap_clk[7:0],  8'b11001100);
    chk("t1_tick", cap_tick[7:0], 8'b10001000);
    chk("t1_run",  running[0], 1'b1);

    // 2: div=3, then div=1 picked up at the wrap
    enable = '0; cycle("t2_stop");
    set_div(0, 3); enable = 4'b0001;
    for (int k = 0; k < 6; k++) cycle("t2a");
    chk("t2_clk3",  cap_clk[5:0],  6'b110110);
    chk("t2_tick3", cap_tick[5:0], 6'b100100);
    set_div(0, 1);
    for (int k = 0; k < 4; k++) cycle("t2b");
    chk("t2_clk1",  cap_clk[3:0],  4'b1111);
    chk("t2_tick1", cap_tick[3:0], 4'b1111);

    // 3: mid-period divisor change waits for the wrap
    enable = '0; cycle("t3_stop");
    set_div(0, 4); enable = 4'b0001;
    cycle("t3a"); cycle("t3a");
    set_div(0, 6);
    for (int k = 0; k < 8; k++) cycle("t3b");
    chk("t3_clk",  cap_clk[7:0],  8'b00111000);
    chk("t3_tick", cap_tick[7:0], 8'b00100000);

    // 4: sync aligns two free-running channels
    enable = '0; cycle("t4_stop");
    set_div(0, 3); set_div(1, 5); enable = 4'b0011;
    for (int k = 0; k < 7; k++) cycle("t4a");
    sync = 1'b1; cycle("t4_sync"); sync = 1'b0;
    chk("t4_tick", tick[1:0], 2'b11);
    cycle("t4b");
    chk("t4_clk_c1", clk_out[1:0], 2'b11);
    cycle("t4c");
    chk("t4_clk_c2", clk_out[1:0], 2'b10);

    // 5: immediate stop, div=0 idling, restart on nonzero div
    enable = '0; cycle("t5_stop");
    set_div(0, 4); enable = 4'b0001;
    for (int k = 0; k < 3; k++) cycle("t5a");
    enable = '0; cycle("t5_off");
    chk("t5_off_outs", {clk_out[0], tick[0], running[0]}, 3'b000);
    set_div(0, 0); enable = 4'b0001;
    for (int k = 0; k < 3; k++) cycle("t5_div0");
    chk("t5_idle", running[0], 1'b0);
    set_div(0, 2); cycle("t5_restart");
    chk("t5_tick", tick[0], 1'b1);

    // 6: asynchronous reset mid-period, clean restart on release
    for (int k = 0; k < 2; k++) cycle("t6a");
    #2 reset = 1'b0;
    #1 chk("t6_async", {clk_out1, tick1, running1, clk_out, tick, running}, 15'd0);
    model_clear();
    @(posedge clk); #1;
    chk("t6_hold", {clk_out1, tick1, running1, clk_out, tick, running}, 15'd0);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) cycle("t6_restart");
    chk("t6_clk", cap_clk[3:0], 4'b1010);

    // Random divisors, enables and sync, including D=255/254 boundaries
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 29) == 0) enable[i] = ~enable[i];
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 9))
            0:       set_div(i, 0);
            1:       set_div(i, 255);
            2:       set_div(i, 254);
            default: set_div(i, int'($urandom_range(1, 9)));
          endcase
        end
      end
      sync = ($urandom_range(0, 24) == 0);
      cycle("rand");
    end
    sync = 1'b0;

    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL scoreboard_drain left=%0d", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
